// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master shift engine.
//   - spi_state_t : transfer sequencer states
//   - MODE_CPOL / MODE_CPHA : bit positions inside the 2-bit mode field
//   - SPI_MODE0..3 : the four standard {CPOL,CPHA} mode encodings
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_shift_master_clk_gen.sv
// SCLK generator for the SPI master.
// Ports:
//   clk, reset  : system clock, synchronous active-low reset
//   run         : counter enable (any non-idle state); clear while low
//   shift_en    : allow sclk toggling on tick (shift phase only)
//   idle        : sequencer idle, sclk tracks idle_pol
//   idle_pol    : live CPOL to park sclk at while idle
//   cpol        : latched CPOL of the current transfer
//   tick        : one-cycle strobe every CLK_DIV enabled cycles
//   lead, trail : tick that produces a leading / trailing sclk edge
//   sclk        : registered SPI clock
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic shift_en,
    input  logic idle,
    input  logic idle_pol,
    input  logic cpol,
    output logic tick,
    output logic lead,
    output logic trail,
    output logic sclk
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] half_cnt_r;
    logic             sclk_r;
    logic             tick_s;
    logic             lead_s;
    logic             trail_s;

    // Half-period counter; held at zero while not running so each transfer starts aligned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            half_cnt_r <= '0;
        end else if (!run) begin
            half_cnt_r <= '0;
        end else if (half_cnt_r == DIV_LAST) begin
            half_cnt_r <= '0;
        end else begin
            half_cnt_r <= half_cnt_r + DIV_W'(1);
        end
    end

    // Tick and edge classification: an edge leaving the CPOL level is a leading edge.
    always_comb begin
        tick_s  = 1'b0;
        lead_s  = 1'b0;
        trail_s = 1'b0;
        if (run && (half_cnt_r == DIV_LAST)) begin
            tick_s  = 1'b1;
            lead_s  = shift_en && (sclk_r == cpol);
            trail_s = shift_en && (sclk_r != cpol);
        end else begin
            tick_s  = 1'b0;
        end
    end

    // SCLK register: parks at the live idle level, toggles only during shifting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_r <= 1'b0;
        end else if (idle) begin
            sclk_r <= idle_pol;
        end else if (tick_s && shift_en) begin
            sclk_r <= ~sclk_r;
        end else begin
            sclk_r <= sclk_r;
        end
    end

    assign tick  = tick_s;
    assign lead  = lead_s;
    assign trail = trail_s;
    assign sclk  = sclk_r;

endmodule

// File: rtl/spi_shift_master.sv
// Full-duplex SPI master shift engine, one chip select.
// Ports:
//   clk, reset    : system clock, synchronous active-low reset
//   start         : transfer request, accepted only while busy=0
//   tx_data       : word to send (latched on accepted start)
//   mode          : {CPOL,CPHA} (latched on accepted start)
//   lsb_first     : bit order (latched on accepted start)
//   rx_data       : received word, updated in the done cycle
//   busy, done    : transfer in progress / one-cycle completion pulse
//   sclk, mosi, cs_n : SPI pin outputs (all registered)
//   miso          : SPI serial input
module spi_shift_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    localparam int CNT_W     = $clog2(2*DATA_WIDTH+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [1:0]            mode,
    input  logic                  lsb_first,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2*DATA_WIDTH - 1);

    // Mirror a word so LSB-first transfers can share the MSB-first shifter.
    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = v[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    spi_state_t            state_r, next_state_s;
    logic [CNT_W-1:0]      edge_cnt_r;
    logic                  cpol_r, cpha_r, lsb_r;
    logic [DATA_WIDTH-1:0] tx_sh_r, rx_sh_r, rx_data_r;
    logic                  mosi_r, cs_n_r, busy_r, done_r;
    logic                  cs_n_nxt_s, busy_nxt_s;
    logic                  idle_s, run_s, shift_en_s, accept_s, finish_s;
    logic                  advance_s, sample_s;
    logic                  tick_s, lead_s, trail_s, sclk_s;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (run_s),
        .shift_en (shift_en_s),
        .idle     (idle_s),
        .idle_pol (mode[MODE_CPOL]),
        .cpol     (cpol_r),
        .tick     (tick_s),
        .lead     (lead_s),
        .trail    (trail_s),
        .sclk     (sclk_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (start) next_state_s = SETUP; else next_state_s = IDLE;
            SETUP:   if (tick_s) next_state_s = SHIFT; else next_state_s = SETUP;
            SHIFT:   if (tick_s && (edge_cnt_r == LAST_EDGE)) next_state_s = HOLD;
                     else next_state_s = SHIFT;
            HOLD:    if (tick_s) next_state_s = IDLE; else next_state_s = HOLD;
            default: next_state_s = IDLE;
        endcase
    end

    // Output/strobe decode; cs_n and busy are derived from the next state so they register in step.
    always_comb begin
        idle_s     = (state_r == IDLE);
        run_s      = !idle_s;
        shift_en_s = (state_r == SHIFT);
        accept_s   = idle_s && start;
        finish_s   = (state_r == HOLD) && tick_s;
        cs_n_nxt_s = (next_state_s == IDLE);
        busy_nxt_s = (next_state_s != IDLE);
        // First leading edge and final trailing edge never move mosi.
        if (cpha_r) begin
            advance_s = lead_s && (edge_cnt_r != '0);
            sample_s  = trail_s;
        end else begin
            advance_s = trail_s && (edge_cnt_r != LAST_EDGE);
            sample_s  = lead_s;
        end
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_n_r <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cs_n_r <= cs_n_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= finish_s;
        end
    end

    // Shadow registers, shifters and edge counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            lsb_r      <= 1'b0;
            tx_sh_r    <= '0;
            rx_sh_r    <= '0;
            rx_data_r  <= '0;
            mosi_r     <= 1'b0;
            edge_cnt_r <= '0;
        end else if (accept_s) begin
            cpol_r     <= mode[MODE_CPOL];
            cpha_r     <= mode[MODE_CPHA];
            lsb_r      <= lsb_first;
            tx_sh_r    <= lsb_first ? bit_rev(tx_data) : tx_data;
            mosi_r     <= lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
            rx_sh_r    <= '0;
            edge_cnt_r <= '0;
        end else begin
            if (tick_s && shift_en_s) begin
                edge_cnt_r <= edge_cnt_r + CNT_W'(1);
            end
            if (advance_s) begin
                tx_sh_r <= tx_sh_r << 1;
                mosi_r  <= tx_sh_r[DATA_WIDTH-2];
            end
            if (sample_s) begin
                rx_sh_r <= {rx_sh_r[DATA_WIDTH-2:0], miso};
            end
            if (finish_s) begin
                rx_data_r <= lsb_r ? bit_rev(rx_sh_r) : rx_sh_r;
            end
        end
    end

    assign rx_data = rx_data_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign sclk    = sclk_s;
    assign mosi    = mosi_r;
    assign cs_n    = cs_n_r;

endmodule

// File: tb/tb_spi_shift_master.sv
// Self-checking bench for spi_shift_master: an 8-bit/CLK_DIV=2 instance
// against a behavioural SPI slave, and a 16-bit/CLK_DIV=1 loopback instance.
module tb_spi_shift_master;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] mode = 2'b00;
    logic       lsb_first = 1'b0;
    logic [7:0] rx_data;
    logic       busy, done, sclk, mosi, miso, cs_n;

    logic        s_start = 1'b0;
    logic [15:0] s_tx = 16'h0000;
    logic [15:0] s_rx;
    logic        s_busy, s_done, s_sclk, s_mosi, s_cs_n;

    int n_checks = 0;
    int n_errors = 0;

    // Slave model configuration (written by the stimulus only).
    logic       lb = 1'b1;
    logic [7:0] sl_word = 8'h00;
    logic       sl_lsb = 1'b0;
    logic       sl_cpol = 1'b0;
    logic       sl_cpha = 1'b0;
    // Slave model state (written by the slave process only).
    logic       slave_miso = 1'b0;
    logic [7:0] sl_rx = 8'h00;
    int         sl_out_idx = 0;
    int         sl_in_idx = 0;
    int         edge_n = 0;
    int         cslow_n = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_cs = 1'b1;

    always #5 clk = ~clk;

    assign miso = lb ? mosi : slave_miso;

    spi_shift_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .mode(mode),
        .lsb_first(lsb_first), .rx_data(rx_data), .busy(busy), .done(done),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_shift_master #(.DATA_WIDTH(16), .CLK_DIV(1)) dut16 (
        .clk(clk), .reset(reset), .start(s_start), .tx_data(s_tx), .mode(SPI_MODE0),
        .lsb_first(1'b0), .rx_data(s_rx), .busy(s_busy), .done(s_done),
        .sclk(s_sclk), .mosi(s_mosi), .miso(s_mosi), .cs_n(s_cs_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sl_bit(input int k);
        return sl_lsb ? sl_word[k] : sl_word[7-k];
    endfunction

    function automatic int sl_pos(input int k);
        return sl_lsb ? k : 7 - k;
    endfunction

    // Behavioural slave: watches pins at the falling clk edge, shifts per CPOL/CPHA rules.
    always @(negedge clk) begin
        prev_sclk <= sclk;
        prev_cs   <= cs_n;
        if (cs_n !== 1'b0) begin
            prev_cs <= cs_n;
        end else if (prev_cs === 1'b1) begin
            sl_in_idx <= 0;
            sl_rx     <= 8'h00;
            edge_n    <= 0;
            cslow_n   <= 1;
            if (!sl_cpha) begin
                slave_miso <= sl_bit(0);
                sl_out_idx <= 1;
            end else begin
                sl_out_idx <= 0;
            end
        end else begin
            cslow_n <= cslow_n + 1;
            if (sclk !== prev_sclk) begin
                edge_n <= edge_n + 1;
                if ((sclk != sl_cpol) == (sl_cpha == 1'b0)) begin
                    // sampling edge
                    if (sl_in_idx < 8) begin
                        sl_rx[sl_pos(sl_in_idx)] <= mosi;
                        sl_in_idx <= sl_in_idx + 1;
                    end
                end else if (sl_out_idx < 8) begin
                    slave_miso <= sl_bit(sl_out_idx);
                    sl_out_idx <= sl_out_idx + 1;
                end
            end
        end
    end

    task automatic start_xfer(input logic [7:0] tx, input logic [1:0] m, input logic l,
                              input logic loop, input logic [7:0] sw);
        mode = m; lb = loop; sl_word = sw; sl_lsb = l; sl_cpol = m[1]; sl_cpha = m[0];
        @(posedge clk); #1;
        check("idle_sclk_before", {31'd0, sclk}, {31'd0, m[1]});
        tx_data = tx; lsb_first = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("first_mosi", {31'd0, mosi}, {31'd0, (l ? tx[0] : tx[7])});
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (done !== 1'b1) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run_xfer(input logic [7:0] tx, input logic [1:0] m, input logic l,
                            input logic loop, input logic [7:0] sw);
        int cyc;
        start_xfer(tx, m, l, loop, sw);
        wait_done(1, cyc);
        check("latency", cyc, 1 + (2*8 + 2)*2);
        check("rx_data", {24'd0, rx_data}, {24'd0, (loop ? tx : sw)});
        if (!loop) check("slave_rx", {24'd0, sl_rx}, {24'd0, tx});
        check("sclk_edges", edge_n, 16);
        check("cs_low_cycles", cslow_n, 36);
        check("done_cs_n", {31'd0, cs_n}, 32'd1);
        check("idle_sclk_after", {31'd0, sclk}, {31'd0, m[1]});
    endtask

    task automatic run16(input logic [15:0] v);
        int cyc;
        @(posedge clk); #1;
        s_tx = v; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 1;
        while (s_done !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w16_latency", cyc, 1 + (2*16 + 2)*1);
        check("w16_rx", {16'd0, s_rx}, {16'd0, v});
    endtask

    initial begin
        int cyc;
        // Reset state, with CPOL=1 applied so sclk=0 is meaningful.
        mode = SPI_MODE2;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rx", {24'd0, rx_data}, 32'd0);
        reset = 1'b1;

        // Loopback, mode 0.
        run_xfer(8'hA5, SPI_MODE0, 1'b0, 1'b1, 8'h00);
        // Slave model, all four modes.
        for (int m = 0; m < 4; m++) run_xfer(8'h3C, 2'(m), 1'b0, 1'b0, 8'hAB);
        // LSB first.
        run_xfer(8'h01, SPI_MODE0, 1'b1, 1'b0, 8'h80);

        // start while busy is ignored.
        start_xfer(8'h5A, SPI_MODE0, 1'b0, 1'b1, 8'h00);
        repeat (9) begin @(posedge clk); #1; end
        tx_data = 8'hFF; lsb_first = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(11, cyc);
        check("ign_latency", cyc, 37);
        check("ign_rx", {24'd0, rx_data}, 32'h5A);
        repeat (3) begin @(posedge clk); #1; end
        check("ign_not_queued", {31'd0, busy}, 32'd0);

        // Back-to-back via start in the done cycle.
        start_xfer(8'hC3, SPI_MODE1, 1'b0, 1'b1, 8'h00);
        wait_done(1, cyc);
        check("b2b_first_rx", {24'd0, rx_data}, 32'hC3);
        check("b2b_done_cs_n", {31'd0, cs_n}, 32'd1);
        tx_data = 8'h3A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_cs_high_1cyc", {31'd0, cs_n}, 32'd0);
        wait_done(1, cyc);
        check("b2b_latency", cyc, 37);
        check("b2b_second_rx", {24'd0, rx_data}, 32'h3A);

        // Reset at cycle 10 of a transfer.
        start_xfer(8'h96, SPI_MODE2, 1'b0, 1'b1, 8'h00);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("mid_rst_sclk", {31'd0, sclk}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rx", {24'd0, rx_data}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0) check("mid_rst_no_done", {31'd0, done}, 32'd0);
        end
        run_xfer(8'h69, SPI_MODE2, 1'b0, 1'b1, 8'h00);

        // Randomised transfers.
        for (int i = 0; i < 10; i++) begin
            run_xfer(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 8'($urandom));
        end

        // 16-bit, CLK_DIV=1 loopback.
        run16(16'hBEEF);
        for (int i = 0; i < 3; i++) run16(16'($urandom));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
